// File: rtl/reg_watch_scanner_pkg.sv
// reg_watch_scanner_pkg
// Shared widths for the register-watch display front-end, plus a helper
// that sizes free-running counters from a cycle count.
package reg_watch_scanner_pkg;

    localparam int REG_NUM_WIDTH   = 5;
    localparam int DATA_WIDTH      = 32;
    localparam int SEG_WIDTH       = 7;
    localparam int DIGIT_COUNT     = 8;
    localparam int DIGIT_IDX_WIDTH = 3;
    localparam int NIBBLE_WIDTH    = 4;

    // A counter that spans 0..n-1 needs at least one bit even when n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_watch_scanner_hex7seg.sv
// hex7seg
// Combinational nibble to 7-segment encoder, active-low, segment order
// {g,f,e,d,c,b,a}. Shared with other display logic.
//   nibble_i : 4-bit value to show
//   seg_o    : active-low segment pattern
module hex7seg
    import reg_watch_scanner_pkg::*;
(
    input  logic [NIBBLE_WIDTH-1:0] nibble_i,
    output logic [SEG_WIDTH-1:0]    seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (nibble_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/reg_watch_scanner.sv
// reg_watch_scanner
// Debug front-end for the CPU register watch port. Selects a register
// (auto dwell timer or manual step), captures its value live and shows it as
// 8 hex digits on a multiplexed active-low 7-segment display.
//   clk, reset  : clock, synchronous active-high reset
//   auto_en     : 1 = auto-advance on dwell timer, 0 = manual step mode
//   step        : debounced level, rising edge advances in manual mode
//   hold        : freezes register number, captured data and dwell timer
//   watch_num   : register number to the register file watch port
//   watch_data  : combinational read data from the watch port
//   an          : digit enables, active low, bit d = nibble d
//   seg         : segments {g,f,e,d,c,b,a}, active low
//   dp          : decimal point, active low (lit on digit 0 while held)
module reg_watch_scanner
    import reg_watch_scanner_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int SCAN_CYCLES  = 100_000
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     auto_en,
    input  logic                     step,
    input  logic                     hold,
    output logic [REG_NUM_WIDTH-1:0] watch_num,
    input  logic [DATA_WIDTH-1:0]    watch_data,
    output logic [DIGIT_COUNT-1:0]   an,
    output logic [SEG_WIDTH-1:0]     seg,
    output logic                     dp
);

    localparam int DWELL_W = cnt_width(DWELL_CYCLES);
    localparam int SCAN_W  = cnt_width(SCAN_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);

    logic [REG_NUM_WIDTH-1:0]   watch_num_q, watch_num_d;
    logic [DWELL_W-1:0]         dwell_q, dwell_d;
    logic [SCAN_W-1:0]          scan_q, scan_d;
    logic [DIGIT_IDX_WIDTH-1:0] digit_q, digit_d;
    logic [DATA_WIDTH-1:0]      cap_q, cap_d;
    logic                       step_q;
    logic                       step_rise;
    logic [DIGIT_COUNT-1:0]     an_q, an_d;
    logic [SEG_WIDTH-1:0]       seg_q, seg_d;
    logic                       dp_q, dp_d;
    logic [NIBBLE_WIDTH-1:0]    nibble;

    assign step_rise = step & ~step_q;

    // Register selection: hold freezes everything, auto mode runs the dwell
    // timer, manual mode keeps it cleared so re-entering auto starts a full
    // dwell period.
    always_comb begin
        watch_num_d = watch_num_q;
        dwell_d     = dwell_q;
        if (!hold) begin
            if (auto_en) begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d     = '0;
                    watch_num_d = watch_num_q + 5'd1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end else begin
                dwell_d = '0;
                if (step_rise) begin
                    watch_num_d = watch_num_q + 5'd1;
                end
            end
        end
    end

    assign cap_d = hold ? cap_q : watch_data;

    // Digit scan is independent of hold so the frozen value stays visible.
    always_comb begin
        scan_d  = scan_q + 1'b1;
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = digit_q + 3'd1;
        end
    end

    assign nibble = cap_q[{digit_q, 2'b00} +: NIBBLE_WIDTH];

    hex7seg u_hex7seg (
        .nibble_i (nibble),
        .seg_o    (seg_d)
    );

    assign an_d = ~({{(DIGIT_COUNT-1){1'b0}}, 1'b1} << digit_q);
    assign dp_d = ~((digit_q == '0) & hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            watch_num_q <= '0;
            dwell_q     <= '0;
            scan_q      <= '0;
            digit_q     <= '0;
            cap_q       <= '0;
            step_q      <= 1'b0;
            an_q        <= '1;
            seg_q       <= '1;
            dp_q        <= 1'b1;
        end else begin
            watch_num_q <= watch_num_d;
            dwell_q     <= dwell_d;
            scan_q      <= scan_d;
            digit_q     <= digit_d;
            cap_q       <= cap_d;
            step_q      <= step;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign watch_num = watch_num_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;

endmodule

// File: tb/tb_reg_watch_scanner.sv
// tb_reg_watch_scanner
// Directed bench for reg_watch_scanner with DWELL_CYCLES=4, SCAN_CYCLES=2.
// A small register-file model answers the watch port (x0 = 0, xi = i+1).
// e_cnt counts clock edges since the last reset release; expected values are
// derived from it and from the bench's own register-file model.
module tb_reg_watch_scanner;

    localparam int DWELL = 4;
    localparam int SCAN  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        auto_en;
    logic        step;
    logic        hold;
    logic [4:0]  watch_num;
    logic [31:0] watch_data;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [31:0] regs [32];

    int n_vec = 0;
    int n_err = 0;
    int e_cnt = 0;

    always #5 clk = ~clk;

    assign watch_data = (watch_num == 5'd0) ? 32'd0 : regs[watch_num];

    reg_watch_scanner #(
        .DWELL_CYCLES (DWELL),
        .SCAN_CYCLES  (SCAN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .auto_en    (auto_en),
        .step       (step),
        .hold       (hold),
        .watch_num  (watch_num),
        .watch_data (watch_data),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [31:0] reg_model(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e_cnt++;
    endtask

    // One reset edge, then release; e_cnt restarts so edge 1 is the first
    // edge with reset low.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; auto_en = 1'b1; step = 1'b0; hold = 1'b0;
        tick();
        tick();
        if (watch_num !== 5'd0) begin n_err++; $display("FAIL reset_num got %0d want 0", watch_num); end
        n_vec++;
        if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an got %h want ff", an); end
        n_vec++;
        if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %b want 1111111", seg); end
        n_vec++;
        if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got %b want 1", dp); end
        n_vec++;
        reset = 1'b0;
        e_cnt = 0;
        tick();
        if (an !== 8'hFE) begin n_err++; $display("FAIL first_an got %h want fe", an); end
        n_vec++;
        if (seg !== 7'b1000000) begin n_err++; $display("FAIL first_seg got %b want 1000000", seg); end
        n_vec++;
    endtask

    // Auto mode from reset release: checks number, capture and digit enable
    // on every edge up to `last`. Continuing past 128 covers the 31->0 wrap.
    task automatic test_auto(input int last, input string tag);
        logic [4:0] exp_num;
        logic [4:0] prev_num;
        logic [7:0] exp_an;
        int         d;
        while (e_cnt < last) begin
            tick();
            exp_num  = 5'(e_cnt / DWELL);
            prev_num = 5'((e_cnt - 1) / DWELL);
            d        = ((e_cnt - 1) / SCAN) % 8;
            exp_an   = 8'hFF ^ (8'h01 << d);
            if (watch_num !== exp_num) begin
                n_err++; $display("FAIL %s_num edge %0d got %0d want %0d", tag, e_cnt, watch_num, exp_num);
            end
            n_vec++;
            if (dut.cap_q !== reg_model(prev_num)) begin
                n_err++; $display("FAIL %s_cap edge %0d got %h want %h", tag, e_cnt, dut.cap_q, reg_model(prev_num));
            end
            n_vec++;
            if (an !== exp_an) begin
                n_err++; $display("FAIL %s_an edge %0d got %h want %h", tag, e_cnt, an, exp_an);
            end
            n_vec++;
        end
    endtask

    task automatic test_auto_wrap();
        test_auto(132, "wrap");
        // edge 125 captured x31, edge 129 captured x0 after the wrap
        if (watch_num !== 5'd1) begin n_err++; $display("FAIL wrap_end_num got %0d want 1", watch_num); end
        n_vec++;
    endtask

    task automatic test_manual();
        auto_en = 1'b0; step = 1'b0; hold = 1'b0;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            repeat (5) tick();
            step = 1'b0;
            repeat (3) tick();
            if (watch_num !== 5'(k)) begin
                n_err++; $display("FAIL manual_pulse%0d got %0d want %0d", k, watch_num, k);
            end
            n_vec++;
        end
        if (dut.cap_q !== 32'h00000004) begin
            n_err++; $display("FAIL manual_cap got %h want 00000004", dut.cap_q);
        end
        n_vec++;
        step = 1'b1;
        repeat (20) tick();
        if (watch_num !== 5'd4) begin n_err++; $display("FAIL manual_long_high got %0d want 4", watch_num); end
        n_vec++;
        step = 1'b0;
        repeat (3) tick();
        if (watch_num !== 5'd4) begin n_err++; $display("FAIL manual_long_after got %0d want 4", watch_num); end
        n_vec++;
    endtask

    task automatic test_hold();
        logic exp_dp;
        int   d;
        auto_en = 1'b1; step = 1'b0; hold = 1'b0;
        do_reset();
        repeat (14) tick();
        if (watch_num !== 5'd3 || dut.cap_q !== 32'h4) begin
            n_err++; $display("FAIL hold_pre got num %0d cap %h want num 3 cap 00000004", watch_num, dut.cap_q);
        end
        n_vec++;
        hold = 1'b1;
        regs[3] = 32'hDEADBEEF;
        repeat (10) begin
            tick();
            d      = ((e_cnt - 1) / SCAN) % 8;
            exp_dp = (d == 0) ? 1'b0 : 1'b1;
            if (watch_num !== 5'd3) begin n_err++; $display("FAIL hold_num edge %0d got %0d want 3", e_cnt, watch_num); end
            n_vec++;
            if (dut.cap_q !== 32'h4) begin n_err++; $display("FAIL hold_cap edge %0d got %h want 00000004", e_cnt, dut.cap_q); end
            n_vec++;
            if (dp !== exp_dp) begin n_err++; $display("FAIL hold_dp edge %0d got %b want %b", e_cnt, dp, exp_dp); end
            n_vec++;
        end
        hold = 1'b0;
        tick();
        if (watch_num !== 5'd3) begin n_err++; $display("FAIL release1_num got %0d want 3", watch_num); end
        n_vec++;
        if (dut.cap_q !== 32'hDEADBEEF) begin n_err++; $display("FAIL release1_cap got %h want deadbeef", dut.cap_q); end
        n_vec++;
        tick();
        if (watch_num !== 5'd4) begin n_err++; $display("FAIL release2_num got %0d want 4", watch_num); end
        n_vec++;
        tick();
        if (dut.cap_q !== 32'h5) begin n_err++; $display("FAIL release3_cap got %h want 00000005", dut.cap_q); end
        n_vec++;
    endtask

    // Continues from test_hold (e_cnt 27, watch_num 4): switch to manual so
    // x4 stays selected, load it with a pattern and watch one full refresh.
    task automatic test_scan();
        logic [31:0] pat;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        int          d;
        pat     = 32'h89ABCDEF;
        auto_en = 1'b0;
        regs[4] = pat;
        tick();
        repeat (16) begin
            tick();
            d       = ((e_cnt - 1) / SCAN) % 8;
            exp_an  = 8'hFF ^ (8'h01 << d);
            exp_seg = seg_of(pat[4*d +: 4]);
            if (an !== exp_an) begin n_err++; $display("FAIL scan_an edge %0d got %h want %h", e_cnt, an, exp_an); end
            n_vec++;
            if (seg !== exp_seg) begin n_err++; $display("FAIL scan_seg digit %0d got %b want %b", d, seg, exp_seg); end
            n_vec++;
            if (dp !== 1'b1) begin n_err++; $display("FAIL scan_dp edge %0d got %b want 1", e_cnt, dp); end
            n_vec++;
        end
        if (watch_num !== 5'd4) begin n_err++; $display("FAIL scan_num got %0d want 4", watch_num); end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b1; step = 1'b0; hold = 1'b0;
        do_reset();
        repeat (22) tick();
        if (watch_num !== 5'd5 || an !== 8'hFB) begin
            n_err++; $display("FAIL mid_pre got num %0d an %h want num 5 an fb", watch_num, an);
        end
        n_vec++;
        reset = 1'b1; hold = 1'b1; step = 1'b1;
        tick();
        if (watch_num !== 5'd0) begin n_err++; $display("FAIL mid_num got %0d want 0", watch_num); end
        n_vec++;
        if (an !== 8'hFF) begin n_err++; $display("FAIL mid_an got %h want ff", an); end
        n_vec++;
        if (seg !== 7'h7F) begin n_err++; $display("FAIL mid_seg got %b want 1111111", seg); end
        n_vec++;
        if (dp !== 1'b1) begin n_err++; $display("FAIL mid_dp got %b want 1", dp); end
        n_vec++;
        reset = 1'b0; hold = 1'b0; step = 1'b0;
        e_cnt = 0;
        tick();
        if (an !== 8'hFE || seg !== 7'b1000000) begin
            n_err++; $display("FAIL mid_release got an %h seg %b want an fe seg 1000000", an, seg);
        end
        n_vec++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'(i + 1);
        test_reset();
        test_auto(13, "auto");
        test_auto_wrap();
        test_manual();
        test_hold();
        test_scan();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
